pea_firing_ctrl: RTL
====================

// Module: pea_firing_ctrl
// PURPOSE
//  Firing controller for the polynomial evaluation actor (PEA).
//  - Pops one command token from the command FIFO and decodes it into mode/arg1/arg2.
//  - Checks FIFO population and free space against the per-mode firing rule.
//  - Issues exactly one exec_start to the PEA datapath, then waits for exec_done.
//  - Sits between the command/data/result/status FIFOs and the PEA datapath.
// PARAMETERS
//  word_size    16    width of command token and FIFO words
//  buffer_size  1024  FIFO depth; CW = log2(buffer_size) count width (10 at default)
// PORTS
//  clk                input   1      clock, rising edge
//  rst                input   1      asynchronous, active-high reset
//  command_pop        input   CW     tokens in command FIFO
//  data_pop           input   CW     tokens in data FIFO
//  result_free_space  input   CW     free slots in result FIFO
//  status_free_space  input   CW     free slots in status FIFO
//  cmd_data           input   word_size  command FIFO head; valid the cycle after cmd_rd_en
//  cmd_rd_en          output  1      one-cycle command FIFO pop
//  next_mode_out      output  2      2'b00 SETUP_INSTR, 2'b01 INSTR
//  mode_out           output  8      decoded opcode: STP=0, EVP=1, EVB=2, RST=3
//  arg1_out           output  3      cmd_data[15:13], coefficient-set id
//  arg2_out           output  5      cmd_data[12:8], degree/count
//  exec_start         output  1      one-cycle datapath start pulse
//  exec_done          input   1      datapath finished; sampled only in EXEC
//  busy               output  1      high in every state except IDLE
//  err_opcode         output  1      one-cycle pulse on an illegal token
//  fire_count         output  16     completed firings, wraps at 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: all outputs are 0, state is IDLE, and mode/arg registers are 0.
//  FSM:
//   - IDLE: next_mode_out = SETUP_INSTR. If command_pop >= 1, assert cmd_rd_en for 1 cycle -> FETCH.
//   - FETCH: capture cmd_data[7:0] into mode, [12:8] into arg2, [15:13] into arg1 -> DECODE.
//   - DECODE: illegal if mode > 3, or (mode == EVP or EVB) with arg2 == 0.
//     Illegal: pulse err_opcode -> IDLE. Legal: next_mode_out = INSTR -> WAIT_EN.
//   - WAIT_EN: evaluate the firing rule each cycle. When true, pulse exec_start -> EXEC.
//   - EXEC: hold mode/args stable. On exec_done, increment fire_count -> IDLE (next cycle).
//  Firing rules (compare in CW+1 bits; arg2 is zero-extended, no overflow):
//   - STP: data_pop >= arg2+1, result_free_space >= 1, status_free_space >= 1
//   - EVP: data_pop >= 1, result_free_space >= arg2, status_free_space >= arg2
//   - EVB: data_pop >= arg2, result_free_space >= arg2, status_free_space >= arg2
//   - RST: always true
//  Latency: cmd_rd_en to exec_start is 3 cycles minimum (FETCH, DECODE, WAIT_EN).
//   exec_done to the next cmd_rd_en is 2 cycles minimum.
//  Boundaries:
//   - Counts exactly at a threshold satisfy the rule (>=).
//   - Rule false forever: stay in WAIT_EN with no timeout.
//   - exec_done in the same cycle as exec_start is ignored; EXEC samples it from the following cycle.
//   - exec_done outside EXEC is ignored.
//   - command_pop == 0: no pop, stay in IDLE.
//   - rst asserted in any state: immediate return to IDLE, no partial pulse completes.
//     fire_count also clears.
//   - Outputs are registered; no combinational path from inputs to exec_start or cmd_rd_en.
// STRUCTURE
//  - Shared package pea_pkg: mode codes STP/EVP/EVB/RST, SETUP_INSTR/INSTR,
//    token field offsets, log2 function.
//  - Sub-module pea_fire_rule: combinational firing-rule check
//    (mode, arg2, counts -> ok). It is also reused by the top-level scheduler.
// TESTING
//  1. Reset mid-EXEC: rst high 1 cycle -> state IDLE; exec_start, cmd_rd_en, fire_count all 0.
//  2. STP, arg2=4, data_pop=4 then 5 -> exec_start only after data_pop=5; mode_out=0, arg2_out=4.
//  3. EVB, arg2=8, result_free_space=7 then 8 -> exec_start in the cycle after the space reaches 8.
//     exec_done -> fire_count=1.
//  4. Token 16'h00_07 (mode 7) -> err_opcode one pulse, no exec_start, back to IDLE.
//     Token EVP with arg2=0 -> err_opcode.
//  5. RST token, all counts 0 -> exec_start 3 cycles after cmd_rd_en.
//  6. Preload fire_count path to 16'hFFFF, complete one firing -> fire_count=0.
//     Back-to-back tokens -> 2-cycle gap between exec_done and next cmd_rd_en.

Source files
------------

// File: rtl/pea_pkg.sv
// -----------------------------------------------------------------------------
// pea_pkg
//   Shared definitions for the polynomial evaluation actor (PEA) firing
//   controller. It holds the opcode values, the next-mode encoding, the field
//   offsets inside a command token, the controller FSM state encoding, and a
//   ceiling-log2 helper that sizes the FIFO count ports.
// -----------------------------------------------------------------------------
package pea_pkg;

  // Opcodes carried in the low byte of a command token.
  localparam logic [7:0] MODE_STP = 8'd0;
  localparam logic [7:0] MODE_EVP = 8'd1;
  localparam logic [7:0] MODE_EVB = 8'd2;
  localparam logic [7:0] MODE_RST = 8'd3;

  // Mode advertised to the surrounding scheduler.
  typedef enum logic [1:0] {
    SETUP_INSTR = 2'b00,
    INSTR       = 2'b01
  } next_mode_t;

  // Command token layout: [15:13] arg1, [12:8] arg2, [7:0] mode.
  localparam int MODE_LSB = 0;
  localparam int MODE_W   = 8;
  localparam int ARG2_LSB = 8;
  localparam int ARG2_W   = 5;
  localparam int ARG1_LSB = 13;
  localparam int ARG1_W   = 3;

  // Controller FSM states. The encoding is visible on the state_dbg port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_WAIT_EN = 3'd3,
    ST_EXEC    = 3'd4
  } state_t;

  // Ceiling log2. A depth of 1024 gives 10.
  function automatic int log2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pea_fire_rule.sv
// -----------------------------------------------------------------------------
// pea_fire_rule
//   Combinational firing-rule check for one PEA firing. Given the decoded mode
//   and arg2, it reports whether the data FIFO holds enough tokens and whether
//   the result and status FIFOs have enough free space.
//   All comparisons are done in count_w+1 bits, so arg2+1 cannot overflow.
// Ports
//   mode               in   8        decoded opcode (STP/EVP/EVB/RST)
//   arg2               in   5        degree/count field, zero-extended
//   data_pop           in   count_w  tokens in data FIFO
//   result_free_space  in   count_w  free slots in result FIFO
//   status_free_space  in   count_w  free slots in status FIFO
//   ok                 out  1        firing rule satisfied (0 for unknown modes)
// -----------------------------------------------------------------------------
module pea_fire_rule
  import pea_pkg::*;
#(
  parameter int count_w = 10
) (
  input  logic [7:0]         mode,
  input  logic [4:0]         arg2,
  input  logic [count_w-1:0] data_pop,
  input  logic [count_w-1:0] result_free_space,
  input  logic [count_w-1:0] status_free_space,
  output logic               ok
);

  localparam logic [count_w:0] one = {{count_w{1'b0}}, 1'b1};

  logic [count_w:0] need;
  logic [count_w:0] need_plus1;
  logic [count_w:0] dp;
  logic [count_w:0] rf;
  logic [count_w:0] sf;

  always_comb begin
    need       = {{(count_w - 4){1'b0}}, arg2};
    need_plus1 = need + one;
    dp         = {1'b0, data_pop};
    rf         = {1'b0, result_free_space};
    sf         = {1'b0, status_free_space};
    ok         = 1'b0;
    case (mode)
      // STP consumes arg2+1 data tokens and emits one result and one status.
      MODE_STP: ok = (dp >= need_plus1) && (rf >= one) && (sf >= one);
      // EVP consumes one data token and emits arg2 results and statuses.
      MODE_EVP: ok = (dp >= one) && (rf >= need) && (sf >= need);
      // EVB is a batch: arg2 tokens in, arg2 results and statuses out.
      MODE_EVB: ok = (dp >= need) && (rf >= need) && (sf >= need);
      MODE_RST: ok = 1'b1;
      default:  ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/pea_firing_ctrl.sv
// -----------------------------------------------------------------------------
// pea_firing_ctrl
//   Firing controller for the polynomial evaluation actor. It pops one command
//   token, decodes it into mode/arg1/arg2, and waits until the FIFO counts
//   satisfy the firing rule for that mode. It then issues one exec_start to the
//   datapath and waits for exec_done.
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   command_pop         in   count_w    tokens in command FIFO
//   data_pop            in   count_w    tokens in data FIFO
//   result_free_space   in   count_w    free slots in result FIFO
//   status_free_space   in   count_w    free slots in status FIFO
//   cmd_data            in   word_size  command FIFO head
//   cmd_rd_en           out  1          one-cycle command FIFO pop
//   next_mode_out       out  2          SETUP_INSTR / INSTR
//   mode_out            out  8          decoded opcode
//   arg1_out            out  3          coefficient-set id
//   arg2_out            out  5          degree/count
//   exec_start          out  1          one-cycle datapath start pulse
//   exec_done           in   1          datapath finished (sampled in EXEC only)
//   busy                out  1          high whenever the FSM is not IDLE
//   err_opcode          out  1          one-cycle pulse on an illegal token
//   fire_count          out  16         completed firings, wraps to 0
//   fc_load             in   1          load fire_count from fc_load_value
//   fc_load_value       in   16         preload value for fire_count
//   state_dbg           out  3          current FSM state (state_t encoding)
//
// Handshakes
//   Command FIFO: cmd_rd_en is high for exactly one cycle (the FETCH cycle).
//   The FIFO presents the popped token on cmd_data in the following cycle
//   (DECODE), and the token fields are registered at the end of that cycle.
//   Datapath: exec_start is high for exactly one cycle, the first EXEC cycle.
//   From the next cycle on, exec_done high for any cycle ends the firing.
//   exec_done is ignored in every other cycle and state.
//   All control outputs come from registers. busy and state_dbg are decoded
//   directly from the state register.
// -----------------------------------------------------------------------------
module pea_firing_ctrl
  import pea_pkg::*;
#(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  parameter int count_w     = log2(buffer_size)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [count_w-1:0]   command_pop,
  input  logic [count_w-1:0]   data_pop,
  input  logic [count_w-1:0]   result_free_space,
  input  logic [count_w-1:0]   status_free_space,
  input  logic [word_size-1:0] cmd_data,
  output logic                 cmd_rd_en,
  output logic [1:0]           next_mode_out,
  output logic [7:0]           mode_out,
  output logic [2:0]           arg1_out,
  output logic [4:0]           arg2_out,
  output logic                 exec_start,
  input  logic                 exec_done,
  output logic                 busy,
  output logic                 err_opcode,
  output logic [15:0]          fire_count,
  input  logic                 fc_load,
  input  logic [15:0]          fc_load_value,
  output logic [2:0]           state_dbg
);

  state_t     state_q, state_d;
  next_mode_t next_mode_q, next_mode_d;
  logic       cmd_rd_en_q, cmd_rd_en_d;
  logic       exec_start_q, exec_start_d;
  logic       err_opcode_q, err_opcode_d;
  logic [7:0] mode_q, mode_d;
  logic [2:0] arg1_q, arg1_d;
  logic [4:0] arg2_q, arg2_d;
  logic [15:0] fire_count_q, fire_count_d;

  logic [7:0] tok_mode;
  logic [2:0] tok_arg1;
  logic [4:0] tok_arg2;
  logic       tok_illegal;
  logic       rule_ok;

  assign tok_mode = cmd_data[MODE_LSB +: MODE_W];
  assign tok_arg2 = cmd_data[ARG2_LSB +: ARG2_W];
  assign tok_arg1 = cmd_data[ARG1_LSB +: ARG1_W];

  // An unknown opcode is illegal. EVP and EVB also need a nonzero count,
  // because a firing with zero outputs would never make progress.
  assign tok_illegal = (tok_mode > MODE_RST) ||
                       (((tok_mode == MODE_EVP) || (tok_mode == MODE_EVB)) &&
                        (tok_arg2 == 5'd0));

  // The rule is checked against the registered mode/args, which stay stable
  // from WAIT_EN to the end of EXEC.
  pea_fire_rule #(
    .count_w (count_w)
  ) u_fire_rule (
    .mode              (mode_q),
    .arg2              (arg2_q),
    .data_pop          (data_pop),
    .result_free_space (result_free_space),
    .status_free_space (status_free_space),
    .ok                (rule_ok)
  );

  always_comb begin
    state_d      = state_q;
    next_mode_d  = next_mode_q;
    cmd_rd_en_d  = 1'b0;
    exec_start_d = 1'b0;
    err_opcode_d = 1'b0;
    mode_d       = mode_q;
    arg1_d       = arg1_q;
    arg2_d       = arg2_q;
    fire_count_d = fire_count_q;

    case (state_q)
      ST_IDLE: begin
        next_mode_d = SETUP_INSTR;
        if (command_pop != '0) begin
          cmd_rd_en_d = 1'b1;
          state_d     = ST_FETCH;
        end
      end

      // The pop is on the FIFO interface this cycle; the token arrives next.
      ST_FETCH: begin
        state_d = ST_DECODE;
      end

      // cmd_data holds the token now: register its fields and judge it.
      ST_DECODE: begin
        mode_d = tok_mode;
        arg1_d = tok_arg1;
        arg2_d = tok_arg2;
        if (tok_illegal) begin
          err_opcode_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          next_mode_d = INSTR;
          state_d     = ST_WAIT_EN;
        end
      end

      // There is no timeout: the controller waits here as long as the rule fails.
      ST_WAIT_EN: begin
        if (rule_ok) begin
          exec_start_d = 1'b1;
          state_d      = ST_EXEC;
        end
      end

      // exec_start_q is high only in the first EXEC cycle, so it also masks
      // an exec_done that arrives together with the start pulse.
      ST_EXEC: begin
        if (exec_done && !exec_start_q) begin
          fire_count_d = fire_count_q + 16'd1;
          next_mode_d  = SETUP_INSTR;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fc_load) begin
      fire_count_d = fc_load_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      next_mode_q  <= SETUP_INSTR;
      cmd_rd_en_q  <= 1'b0;
      exec_start_q <= 1'b0;
      err_opcode_q <= 1'b0;
      mode_q       <= 8'd0;
      arg1_q       <= 3'd0;
      arg2_q       <= 5'd0;
      fire_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      next_mode_q  <= next_mode_d;
      cmd_rd_en_q  <= cmd_rd_en_d;
      exec_start_q <= exec_start_d;
      err_opcode_q <= err_opcode_d;
      mode_q       <= mode_d;
      arg1_q       <= arg1_d;
      arg2_q       <= arg2_d;
      fire_count_q <= fire_count_d;
    end
  end

  assign cmd_rd_en     = cmd_rd_en_q;
  assign exec_start    = exec_start_q;
  assign err_opcode    = err_opcode_q;
  assign next_mode_out = next_mode_q;
  assign mode_out      = mode_q;
  assign arg1_out      = arg1_q;
  assign arg2_out      = arg2_q;
  assign fire_count    = fire_count_q;
  assign busy          = (state_q != ST_IDLE);
  assign state_dbg     = state_q;

endmodule
